systolic_mmu_nxn: RTL and testbench
===================================

Name: systolic_mmu_nxn

Overview:
- Parametrised successor of the 2x2 MMU-plus-accumulator top level: an N x N weight-stationary systolic array with built-in input skew, output de-skew and per-column accumulators.
- A control FSM gates weight loading and tracks in-flight vectors so that weights never change under live data.
- Sits between the activation/weight buffers and the writeback path; one input vector in per cycle, one result vector out per cycle.

Parameters:
N, 2, array dimension (rows = input vector length, columns = output vector length); legal range 2..8
DATA_W, 16, signed two's-complement width of activations and weights
ACC_W, 32, signed width of column partial sums and accumulators; must be >= 2*DATA_W + clog2(N)
CNT_W, 16, width of accumulated-vector counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
load_weight  in  1  load all weights from w_in this cycle (accepted only when busy=0)
w_in  in  N*N*DATA_W  weights; W[i][j] = w_in[(i*N+j)*DATA_W +: DATA_W]
in_valid  in  1  a_in holds a valid activation vector this cycle
a_in  in  N*DATA_W  activation vector; a[i] = a_in[i*DATA_W +: DATA_W]
acc_clear  in  1  zero accumulators and counter
busy  out  1  one or more vectors in flight
out_valid  out  1  res_out valid this cycle
res_out  out  N*ACC_W  result vector; column j = res_out[j*ACC_W +: ACC_W]
acc_out  out  N*ACC_W  running per-column accumulator values, same packing
acc_count  out  CNT_W  vectors accumulated since last clear

Behaviour:
- Reset (reset=0, async): all weights, PE pipeline registers, skew/de-skew registers, accumulators, acc_count, in-flight counter = 0; FSM -> IDLE; busy=0, out_valid=0, res_out=0, acc_out=0.
- Math: res[j] = sum over i of a[i]*W[i][j]; signed multiply, signed add; sign-extend to ACC_W; wrap modulo 2^ACC_W with no saturation.
- Dataflow: a[i] is delayed i cycles by the input skew, then enters row i and moves one column right per cycle. Partial sums move down one row per cycle. Column j output is delayed (N-1-j) cycles by the de-skew.
- Latency: a vector accepted at cycle t gives out_valid=1 with its res_out at cycle t+2N exactly. Back-to-back inputs give back-to-back outputs; order is preserved.
- Bubbles: no out_valid for cycles where in_valid was 0 (valid bit pipeline of depth 2N). res_out holds its last value when out_valid=0.
- FSM:
  - IDLE: busy=0. Go to RUN on in_valid.
  - RUN: go to DRAIN when in_valid=0 and in-flight > 0.
  - DRAIN: back to RUN on in_valid; go to IDLE when in-flight reaches 0.
- In-flight counter: +1 on accept, -1 on out_valid, both in the same cycle = no change; range 0..2N.
- busy = (in-flight != 0) OR in_valid.
- Weight load:
  - With busy=0: W <= w_in at the edge.
  - With busy=1: load_weight is ignored and weights are unchanged.
  - load_weight and in_valid in the same cycle while idle: the weights load first, and that vector uses the new weights.
- Accumulator: on out_valid, acc[j] <= acc[j] + res[j] and acc_count <= acc_count + 1. acc_count saturates at 2^CNT_W-1.
- acc_clear without out_valid: acc = 0, acc_count = 0.
- acc_clear together with out_valid: acc[j] <= res[j], acc_count <= 1 (clear then add).
- acc_out is registered and updates the cycle after the triggering edge inputs.
- Reset asserted mid-stream: all in-flight data is dropped, and no out_valid occurs after reset release until new inputs have made the full 2N-cycle trip.

Test Plan:
- Basic: N=2, load W=[[1,2],[3,4]], a=[5,6] at t0 -> out_valid at t0+4 only; res=[23,34]; acc=[23,34]; acc_count=1.
- Streaming: same W, a=[5,6] then [1,1] on consecutive cycles -> res [23,34] then [4,6]; acc=[27,40]; busy stays 1 until the second output, then 0.
- Signed/wrap: W all 0x8000, a=[0x8000,0x8000] -> res[j] = 2*2^30 = 0x80000000, reported as the signed value -2^31 because the sum wraps at ACC_W=32.
- Weight interlock: while busy=1, pulse load_weight with W all zeros -> in-flight results are unchanged. A load issued after busy=0 takes effect, and the next vector gives res=[0,0].
- acc_clear coincident with out_valid -> acc equals that res, acc_count=1. acc_clear alone -> acc=0, acc_count=0.
- Reset mid-stream: three vectors in, reset asserted low for one cycle -> all outputs 0, no spurious out_valid, and a fresh vector afterwards produces a correct result at t+2N with W=0 (weights were cleared).

Source files
------------

// File: rtl/systolic_mmu_nxn.sv
// N x N weight-stationary systolic matrix unit: skewed activations enter the rows,
// partial sums flow down the columns, de-skewed results feed per-column accumulators.
module systolic_mmu_nxn #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_weight,
    input  logic [N*N*DATA_W-1:0]     w_in,
    input  logic                      in_valid,
    input  logic [N*DATA_W-1:0]       a_in,
    input  logic                      acc_clear,
    output logic                      busy,
    output logic                      out_valid,
    output logic [N*ACC_W-1:0]        res_out,
    output logic [N*ACC_W-1:0]        acc_out,
    output logic [CNT_W-1:0]          acc_count
);

    // state | meaning
    // IDLE  | nothing in flight, weight loads accepted
    // RUN   | vectors arriving, weights frozen
    // DRAIN | no new input, waiting for in-flight vectors to emerge
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEPTH = 2 * N;
    localparam int IF_W  = $clog2(DEPTH + 1);

    state_t                  state_q, state_d;
    logic [IF_W-1:0]         inflight_q, inflight_d;
    logic [DEPTH-1:0]        vld_q;
    logic                    load_ok;

    logic signed [DATA_W-1:0] w_q  [N][N];
    logic signed [DATA_W-1:0] a_q  [N][N];
    logic signed [ACC_W-1:0]  ps_q [N][N];
    logic signed [ACC_W-1:0]  prod [N][N];
    logic [N*DATA_W-1:0]      row_in;
    logic [N*ACC_W-1:0]       res_cur;
    logic [N*ACC_W-1:0]       res_hold_q;
    logic [ACC_W-1:0]         acc_q [N];
    logic [CNT_W-1:0]         cnt_q;

    assign out_valid = vld_q[DEPTH-1];
    assign busy      = (inflight_q != '0) || in_valid;
    // IDLE implies an empty pipeline, so a load issued alongside the first vector lands first
    assign load_ok   = load_weight && (state_q == IDLE);

    always_comb begin
        inflight_d = inflight_q;
        if (in_valid && !out_valid)
            inflight_d = inflight_q + IF_W'(1);
        else if (!in_valid && out_valid)
            inflight_d = inflight_q - IF_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (!in_valid) state_d = (inflight_d != '0) ? DRAIN : IDLE;
            DRAIN: begin
                if (in_valid)
                    state_d = RUN;
                else if (inflight_d == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            vld_q      <= {vld_q[DEPTH-2:0], in_valid};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w_q[i][j] <= '0;
        end else if (load_ok) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w_q[i][j] <= w_in[(i*N+j)*DATA_W +: DATA_W];
        end
    end

    // Row i waits i cycles here; the array's first column register adds one more.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign row_in[0 +: DATA_W] = a_in[0 +: DATA_W];
        end else begin : g_delay
            logic [DATA_W-1:0] sr [i];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < i; k++)
                        sr[k] <= '0;
                end else begin
                    sr[0] <= a_in[i*DATA_W +: DATA_W];
                    for (int k = 1; k < i; k++)
                        sr[k] <= sr[k-1];
                end
            end
            assign row_in[i*DATA_W +: DATA_W] = sr[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = ACC_W'((2*DATA_W)'(a_q[i][j]) * (2*DATA_W)'(w_q[i][j]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_q[i][j]  <= '0;
                    ps_q[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_q[i][0] <= row_in[i*DATA_W +: DATA_W];
                for (int j = 1; j < N; j++)
                    a_q[i][j] <= a_q[i][j-1];
            end
            for (int j = 0; j < N; j++) begin
                ps_q[0][j] <= prod[0][j];
                for (int i = 1; i < N; i++)
                    ps_q[i][j] <= ps_q[i-1][j] + prod[i][j];
            end
        end
    end

    // Column j leaves the array j cycles after column 0; delay it N-1-j to realign.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        if (j == N - 1) begin : g_direct
            assign res_cur[j*ACC_W +: ACC_W] = ps_q[N-1][j];
        end else begin : g_delay
            logic [ACC_W-1:0] dq [N-1-j];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < N - 1 - j; k++)
                        dq[k] <= '0;
                end else begin
                    dq[0] <= ps_q[N-1][j];
                    for (int k = 1; k < N - 1 - j; k++)
                        dq[k] <= dq[k-1];
                end
            end
            assign res_cur[j*ACC_W +: ACC_W] = dq[N-2-j];
        end
    end

    assign res_out = out_valid ? res_cur : res_hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_hold_q <= '0;
            cnt_q      <= '0;
            for (int j = 0; j < N; j++)
                acc_q[j] <= '0;
        end else if (out_valid) begin
            res_hold_q <= res_cur;
            for (int j = 0; j < N; j++)
                acc_q[j] <= (acc_clear ? '0 : acc_q[j]) + res_cur[j*ACC_W +: ACC_W];
            if (acc_clear)
                cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end else if (acc_clear) begin
            cnt_q <= '0;
            for (int j = 0; j < N; j++)
                acc_q[j] <= '0;
        end
    end

    always_comb begin
        acc_out = '0;
        for (int j = 0; j < N; j++)
            acc_out[j*ACC_W +: ACC_W] = acc_q[j];
    end

    assign acc_count = cnt_q;

endmodule

// File: tb/tb_systolic_mmu_nxn.sv
// Bench for systolic_mmu_nxn: queue-based reference model checked every cycle,
// directed scenarios pinned to hand-computed results, then randomized traffic.
module tb_systolic_mmu_nxn;

    localparam int N      = 2;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  load_weight = 1'b0;
    logic [N*N*DATA_W-1:0] w_in = '0;
    logic                  in_valid = 1'b0;
    logic [N*DATA_W-1:0]   a_in = '0;
    logic                  acc_clear = 1'b0;
    logic                  busy, out_valid;
    logic [N*ACC_W-1:0]    res_out, acc_out;
    logic [CNT_W-1:0]      acc_count;

    systolic_mmu_nxn #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset_n), .load_weight(load_weight), .w_in(w_in),
        .in_valid(in_valid), .a_in(a_in), .acc_clear(acc_clear), .busy(busy),
        .out_valid(out_valid), .res_out(res_out), .acc_out(acc_out), .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int                 due;
        logic [N*ACC_W-1:0] res;
    } ent_t;

    ent_t                  q[$];
    int                    edge_cnt = 0;
    logic [N*N*DATA_W-1:0] w_m = '0;
    logic [N*ACC_W-1:0]    acc_m = '0;
    logic [N*ACC_W-1:0]    last_res = '0;
    int                    cnt_m = 0;

    function automatic logic [N*ACC_W-1:0] model_mul(input logic [N*DATA_W-1:0] a);
        logic [N*ACC_W-1:0] r;
        longint s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += longint'($signed(a[i*DATA_W +: DATA_W])) *
                     longint'($signed(w_m[(i*N+j)*DATA_W +: DATA_W]));
            r[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: weights change only with nothing in flight; each accepted
    // vector's result is due 2N cycles later and folds into the accumulators.
    always @(posedge clk) begin
        ent_t e;
        logic [N*ACC_W-1:0] r;
        edge_cnt++;
        if (!reset_n) begin
            q.delete();
            w_m = '0; acc_m = '0; last_res = '0; cnt_m = 0;
        end else begin
            if (load_weight && q.size() == 0)
                w_m = w_in;
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                r = q[0].res;
                void'(q.pop_front());
                last_res = r;
                for (int j = 0; j < N; j++) begin
                    if (acc_clear)
                        acc_m[j*ACC_W +: ACC_W] = r[j*ACC_W +: ACC_W];
                    else
                        acc_m[j*ACC_W +: ACC_W] = acc_m[j*ACC_W +: ACC_W] + r[j*ACC_W +: ACC_W];
                end
                if (acc_clear) cnt_m = 1;
                else if (cnt_m < CMAX) cnt_m++;
            end else if (acc_clear) begin
                acc_m = '0;
                cnt_m = 0;
            end
            if (in_valid) begin
                e.due = edge_cnt + 2 * N;
                e.res = model_mul(a_in);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic exp_ov;
        if (reset_n) begin
            exp_ov = (q.size() > 0) && (q[0].due == edge_cnt + 1);
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("res_out", 64'(res_out), 64'(exp_ov ? q[0].res : last_res));
            check("acc_out", 64'(acc_out), 64'(acc_m));
            check("acc_count", 64'(acc_count), 64'(cnt_m));
            check("busy", 64'(busy), 64'((q.size() != 0) || in_valid));
        end
    end

    task automatic drive(input logic lw, input logic [N*N*DATA_W-1:0] w, input logic iv,
                         input logic [N*DATA_W-1:0] a, input logic clr);
        load_weight = lw; w_in = w; in_valid = iv; a_in = a; acc_clear = clr;
        @(posedge clk); #1;
        load_weight = 1'b0; in_valid = 1'b0; acc_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic [63:0] exp, input int maxc);
        int k;
        k = 0;
        while (!out_valid && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL %s: out_valid got 0 expected 1 within %0d cycles", name, maxc);
        end else begin
            check(name, 64'(res_out), exp);
        end
    endtask

    function automatic logic [N*N*DATA_W-1:0] wpk(input int w00, input int w01, input int w10, input int w11);
        return {16'(w11), 16'(w10), 16'(w01), 16'(w00)};
    endfunction

    function automatic logic [N*DATA_W-1:0] apk(input int a0, input int a1);
        return {16'(a1), 16'(a0)};
    endfunction

    function automatic logic [63:0] rpk(input int r0, input int r1);
        return {32'(r1), 32'(r0)};
    endfunction

    initial begin
        logic [N*N*DATA_W-1:0] w1, wneg;
        w1   = wpk(1, 2, 3, 4);
        wneg = {4{16'h8000}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_out", 64'(res_out), 64'd0);
        check("rst_acc_out", 64'(acc_out), 64'd0);
        check("rst_acc_count", 64'(acc_count), 64'd0);
        reset_n = 1'b1;

        // basic
        drive(1'b1, w1, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        idle(2 * N - 1);
        check("basic_valid_at_2n", 64'(out_valid), 64'd1);
        check("basic_res", 64'(res_out), rpk(23, 34));
        idle(1);
        check("basic_acc", 64'(acc_out), rpk(23, 34));
        check("basic_cnt", 64'(acc_count), 64'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("clear_acc", 64'(acc_out), 64'd0);
        check("clear_cnt", 64'(acc_count), 64'd0);

        // streaming
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        drive(1'b0, '0, 1'b1, apk(1, 1), 1'b0);
        expect_out("stream_res0", rpk(23, 34), 8);
        idle(1);
        check("stream_valid1", 64'(out_valid), 64'd1);
        check("stream_res1", 64'(res_out), rpk(4, 6));
        idle(1);
        check("stream_acc", 64'(acc_out), rpk(27, 40));
        check("stream_busy_done", 64'(busy), 64'd0);

        // signed wrap
        drive(1'b1, wneg, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, {2{16'h8000}}, 1'b0);
        expect_out("signed_wrap", {2{32'h8000_0000}}, 8);
        idle(2);

        // weight interlock
        drive(1'b1, w1, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        drive(1'b1, '0, 1'b0, '0, 1'b0);
        expect_out("interlock_kept", rpk(23, 34), 8);
        idle(2);
        drive(1'b1, '0, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        expect_out("interlock_zero", 64'd0, 8);
        idle(2);

        // load and vector in the same idle cycle
        drive(1'b1, w1, 1'b1, apk(5, 6), 1'b0);
        expect_out("load_first", rpk(23, 34), 8);
        idle(2);

        // clear coincident with out_valid
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        expect_out("coinc_res", rpk(23, 34), 8);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("coinc_acc", 64'(acc_out), rpk(23, 34));
        check("coinc_cnt", 64'(acc_count), 64'd1);

        // counter saturation
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        for (int k = 0; k < CMAX + 2; k++) drive(1'b0, '0, 1'b1, apk(k, 1), 1'b0);
        idle(2 * N + 2);
        check("cnt_saturate", 64'(acc_count), 64'(CMAX));

        // randomized traffic in bursts of varying density
        for (int b = 0; b < 25; b++) begin
            int dens;
            dens = $urandom_range(0, 4);
            for (int k = 0; k < 16; k++)
                drive($urandom_range(0, 5) == 0, {$urandom, $urandom},
                      $urandom_range(0, 3) < dens, N*DATA_W'($urandom),
                      $urandom_range(0, 19) == 0);
        end
        idle(2 * N + 2);

        // reset mid-stream
        drive(1'b1, w1, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        drive(1'b0, '0, 1'b1, apk(1, 1), 1'b0);
        drive(1'b0, '0, 1'b1, apk(7, -3), 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_res", 64'(res_out), 64'd0);
        check("mid_rst_acc", 64'(acc_out), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2 * N + 2);
        drive(1'b0, '0, 1'b1, apk(5, 6), 1'b0);
        expect_out("post_rst_zero_w", 64'd0, 8);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
